nj_mem_arbiter: RTL and testbench

- Shares one single-port synchronous RAM (AW x DW, 1-cycle read latency) among three NanoJeff requesters: the host/loader port, the CPU data port and the CPU instruction-fetch port.
- Sits between the NanoJeff core and on-chip RAM. It replaces the dual combinational read path with a granted, stallable handshake.
- Arbitration: the host has fixed top priority, with a burst limit. Data and ifetch are round-robin.

---
 rtl/nj_pkg.sv | 15 +
 rtl/nj_mem_arbiter_if.sv | 39 +++
 rtl/nj_rr2.sv | 34 +++
 rtl/nj_mem_arbiter.sv | 93 +++++++++
 tb/tb_nj_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nj_pkg.sv
// Shared types and defaults for the NanoJeff memory arbiter slice.
package nj_pkg;

    localparam int unsigned NJ_AW = 8;
    localparam int unsigned NJ_DW = 8;

    // Identifies which requester owns a RAM slot or an outstanding read return.
    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_HOST   = 2'd1,
        SRC_DATA   = 2'd2,
        SRC_IFETCH = 2'd3
    } src_t;

endpackage

// File: rtl/nj_mem_arbiter_if.sv
// Requester handshakes plus the single-port RAM bus seen by the arbiter.
interface nj_mem_arbiter_if
    import nj_pkg::*;
#(
    parameter int unsigned AW = NJ_AW,
    parameter int unsigned DW = NJ_DW
);
    logic          h_req, h_wen, h_gnt, h_rvalid;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;

    logic          d_req, d_wen, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;

    logic          i_req, i_gnt, i_rvalid;
    logic [AW-1:0] i_addr;

    logic [DW-1:0] rdata;

    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    modport slave (
        input  h_req, h_wen, h_addr, h_wdata, d_req, d_wen, d_addr, d_wdata,
               i_req, i_addr, mem_rdata,
        output h_gnt, h_rvalid, d_gnt, d_rvalid, i_gnt, i_rvalid, rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output h_req, h_wen, h_addr, h_wdata, d_req, d_wen, d_addr, d_wdata,
               i_req, i_addr, mem_rdata,
        input  h_gnt, h_rvalid, d_gnt, d_rvalid, i_gnt, i_rvalid, rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/nj_rr2.sv
// Two-way round-robin picker; bit 0 is the data port, bit 1 the ifetch port.
module nj_rr2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic rr_q, rr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    // The pointer only moves on a real contest; a lone requester leaves it alone.
    always_comb begin
        rr_d = (req == 2'b11) ? ~rr_q : rr_q;
    end

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/nj_mem_arbiter.sv
// Grants one single-port RAM to host, CPU data and CPU ifetch requesters and
// steers the one-cycle read return back to the port that issued the read.
module nj_mem_arbiter
    import nj_pkg::*;
#(
    parameter int unsigned AW         = NJ_AW,
    parameter int unsigned DW         = NJ_DW,
    parameter int unsigned HOST_BURST = 4
) (
    input logic             clk,
    input logic             reset,
    nj_mem_arbiter_if.slave bus
);

    localparam logic [3:0] BurstMax = 4'(HOST_BURST);

    logic [3:0]    burst_q, burst_d;
    src_t          tag_q, tag_d, gsrc;
    logic          dv_pending, host_win, gnt_we;
    logic [1:0]    dv_req, dv_gnt;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_wdata;

    assign dv_pending = bus.d_req | bus.i_req;
    // Host yields exactly one slot once its contended streak reaches the limit.
    assign host_win   = reset & bus.h_req & ~((burst_q == BurstMax) & dv_pending);
    assign dv_req     = {bus.i_req, bus.d_req} & {2{reset & ~host_win}};
    assign gsrc       = host_win  ? SRC_HOST :
                        dv_gnt[0] ? SRC_DATA :
                        dv_gnt[1] ? SRC_IFETCH : SRC_NONE;

    nj_rr2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (dv_req),
        .gnt   (dv_gnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_q <= '0;
            tag_q   <= SRC_NONE;
        end else begin
            burst_q <= burst_d;
            tag_q   <= tag_d;
        end
    end

    // An uncontended host never accumulates a streak, so it can stream forever.
    always_comb begin
        burst_d = '0;
        if (gsrc == SRC_HOST && dv_pending) begin
            burst_d = (burst_q >= BurstMax) ? BurstMax : burst_q + 4'd1;
        end
        tag_d = (gsrc != SRC_NONE && !gnt_we) ? gsrc : SRC_NONE;
    end

    always_comb begin
        gnt_we    = 1'b0;
        gnt_addr  = '0;
        gnt_wdata = '0;
        unique case (gsrc)
            SRC_HOST: begin
                gnt_we    = bus.h_wen;
                gnt_addr  = bus.h_addr;
                gnt_wdata = bus.h_wdata;
            end
            SRC_DATA: begin
                gnt_we    = bus.d_wen;
                gnt_addr  = bus.d_addr;
                gnt_wdata = bus.d_wdata;
            end
            SRC_IFETCH: begin
                gnt_addr  = bus.i_addr;
            end
            default: ;
        endcase

        bus.h_gnt     = (gsrc == SRC_HOST);
        bus.d_gnt     = (gsrc == SRC_DATA);
        bus.i_gnt     = (gsrc == SRC_IFETCH);
        bus.mem_en    = (gsrc != SRC_NONE);
        bus.mem_we    = gnt_we;
        bus.mem_addr  = gnt_addr;
        bus.mem_wdata = gnt_wdata;

        bus.h_rvalid  = (tag_q == SRC_HOST);
        bus.d_rvalid  = (tag_q == SRC_DATA);
        bus.i_rvalid  = (tag_q == SRC_IFETCH);
        bus.rdata     = (tag_q != SRC_NONE) ? bus.mem_rdata : '0;
    end

endmodule

// File: tb/tb_nj_mem_arbiter.sv
// Self-checking bench: reset-state vector table, directed corner sequences and a
// randomized run against a rule-level model with a shadow copy of the RAM.
module tb_nj_mem_arbiter;
    import nj_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned HB = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    nj_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    nj_mem_arbiter #(.AW(AW), .DW(DW), .HOST_BURST(HB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM model: 1-cycle read latency, plus a back-door poke port for preloading.
    logic [7:0] ram [256];
    logic       poke_en = 1'b0;
    logic [7:0] poke_addr = 8'h00;
    logic [7:0] poke_data = 8'h00;

    always @(posedge clk) begin
        if (poke_en) begin
            ram[poke_addr] = poke_data;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
            else bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: spec-level rules, shadow memory, pending return.
    bit         m_rr = 1'b0;
    int         m_run = 0;
    int         m_tag = 0;
    logic [7:0] m_tdata = 8'h00;
    logic [7:0] m_mem [256];
    int         seen_src = 0;

    typedef struct {
        string      name;
        logic       h_req, h_wen, d_req, d_wen, i_req;
        logic [2:0] gnt;
        logic       we;
        logic [7:0] addr, wdata;
    } vec_t;
    vec_t vecs[8];

    int order[4] = '{2, 3, 2, 3};
    int burst_exp[9] = '{1, 1, 1, 1, 2, 1, 1, 1, 1};
    int gs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_src();
        if (!reset) return 0;
        if (bus.h_req && !(m_run >= int'(HB) && (bus.d_req || bus.i_req))) return 1;
        if (bus.d_req && bus.i_req) return m_rr ? 3 : 2;
        if (bus.d_req) return 2;
        if (bus.i_req) return 3;
        return 0;
    endfunction

    task automatic grant_info(input int g, output logic we, output logic [7:0] a,
                              output logic [7:0] wd);
        we = 1'b0; a = 8'h00; wd = 8'h00;
        case (g)
            1: begin we = bus.h_wen; a = bus.h_addr; wd = bus.h_wdata; end
            2: begin we = bus.d_wen; a = bus.d_addr; wd = bus.d_wdata; end
            3: a = bus.i_addr;
            default: ;
        endcase
    endtask

    task automatic check_now();
        int g, t;
        logic we;
        logic [7:0] a, wd;
        g = exp_src();
        t = reset ? m_tag : 0;
        grant_info(g, we, a, wd);
        chk("h_gnt", 32'(bus.h_gnt), 32'(g == 1));
        chk("d_gnt", 32'(bus.d_gnt), 32'(g == 2));
        chk("i_gnt", 32'(bus.i_gnt), 32'(g == 3));
        chk("mem_en", 32'(bus.mem_en), 32'(g != 0));
        chk("mem_we", 32'(bus.mem_we), 32'(we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(a));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(wd));
        chk("h_rvalid", 32'(bus.h_rvalid), 32'(t == 1));
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(t == 2));
        chk("i_rvalid", 32'(bus.i_rvalid), 32'(t == 3));
        chk("rdata", 32'(bus.rdata), (t != 0) ? 32'(m_tdata) : 32'h0);
    endtask

    task automatic model_step();
        int g;
        logic we;
        logic [7:0] a, wd;
        if (!reset) begin
            m_rr = 1'b0; m_run = 0; m_tag = 0;
            return;
        end
        g = exp_src();
        grant_info(g, we, a, wd);
        m_tag = (g != 0 && !we) ? g : 0;
        if (m_tag != 0) m_tdata = m_mem[a];
        if (g != 0 && we) m_mem[a] = wd;
        m_run = (g == 1 && (bus.d_req || bus.i_req)) ? m_run + 1 : 0;
        if (bus.d_req && bus.i_req && g >= 2) m_rr = !m_rr;
    endtask

    task automatic cyc_pre();
        @(negedge clk);
        seen_src = bus.h_gnt ? 1 : bus.d_gnt ? 2 : bus.i_gnt ? 3 : 0;
    endtask

    task automatic cyc_post();
        check_now();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycle();
        cyc_pre();
        cyc_post();
    endtask

    task automatic idle();
        bus.h_req = 1'b0; bus.h_wen = 1'b0; bus.h_addr = 8'h00; bus.h_wdata = 8'h00;
        bus.d_req = 1'b0; bus.d_wen = 1'b0; bus.d_addr = 8'h00; bus.d_wdata = 8'h00;
        bus.i_req = 1'b0; bus.i_addr = 8'h00;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        poke_en = 1'b1; poke_addr = a; poke_data = v;
        m_mem[a] = v;
        cycle();
        poke_en = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        bit got_d_rv;
        idle();
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));

        // Single-cycle decisions straight out of reset (rr=0, no streak).
        vecs[0] = '{"none",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 8'h00};
        vecs[1] = '{"host_rd", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 8'h11, 8'hA1};
        vecs[2] = '{"h_wr_d",  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 8'h11, 8'hA1};
        vecs[3] = '{"data_wr", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 8'h22, 8'hD2};
        vecs[4] = '{"ifetch",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 8'h33, 8'h00};
        vecs[5] = '{"d_vs_i",  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 8'h22, 8'hD2};
        vecs[6] = '{"all",     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b100, 1'b0, 8'h11, 8'hA1};
        vecs[7] = '{"dwr_vs_i", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b1, 8'h22, 8'hD2};
        for (int k = 0; k < 8; k++) begin
            reset = 1'b0;
            bus.h_addr = 8'h11; bus.h_wdata = 8'hA1;
            bus.d_addr = 8'h22; bus.d_wdata = 8'hD2; bus.i_addr = 8'h33;
            bus.h_req = vecs[k].h_req; bus.h_wen = vecs[k].h_wen;
            bus.d_req = vecs[k].d_req; bus.d_wen = vecs[k].d_wen;
            bus.i_req = vecs[k].i_req;
            cycle();
            reset = 1'b1;
            cyc_pre();
            chk({vecs[k].name, ".gnt"}, 32'({bus.h_gnt, bus.d_gnt, bus.i_gnt}),
                32'(vecs[k].gnt));
            chk({vecs[k].name, ".en"}, 32'(bus.mem_en), 32'(vecs[k].gnt != 3'b000));
            chk({vecs[k].name, ".we"}, 32'(bus.mem_we), 32'(vecs[k].we));
            chk({vecs[k].name, ".addr"}, 32'(bus.mem_addr), 32'(vecs[k].addr));
            chk({vecs[k].name, ".wdata"}, 32'(bus.mem_wdata), 32'(vecs[k].wdata));
            cyc_post();
        end
        idle();
        cycle();
        cycle();

        // Lone ifetch of a known word.
        poke(8'h05, 8'hBF);
        bus.i_req = 1'b1; bus.i_addr = 8'h05;
        cyc_pre();
        chk("lone_i_gnt", 32'(bus.i_gnt), 32'h1);
        chk("lone_i_en", 32'(bus.mem_en), 32'h1);
        chk("lone_i_we", 32'(bus.mem_we), 32'h0);
        chk("lone_i_addr", 32'(bus.mem_addr), 32'h05);
        cyc_post();
        bus.i_req = 1'b0;
        cyc_pre();
        chk("lone_i_rvalid", 32'(bus.i_rvalid), 32'h1);
        chk("lone_i_rdata", 32'(bus.rdata), 32'hBF);
        cyc_post();

        // Data/ifetch contention straight after reset.
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        bus.d_req = 1'b1; bus.d_wen = 1'b0; bus.d_addr = 8'h10;
        bus.i_req = 1'b1; bus.i_addr = 8'h02;
        for (int k = 0; k < 4; k++) begin
            cyc_pre();
            chk("rr_order", 32'(seen_src), 32'(order[k]));
            if (k > 0) begin
                chk("rr_ret_d", 32'(bus.d_rvalid), 32'(order[k-1] == 2));
                chk("rr_ret_i", 32'(bus.i_rvalid), 32'(order[k-1] == 3));
            end
            cyc_post();
        end
        idle();
        cyc_pre();
        chk("rr_last_ret", 32'(bus.i_rvalid), 32'h1);
        cyc_post();

        // Host write burst against a pending data read.
        n = 0;
        got_d_rv = 1'b0;
        bus.h_req = 1'b1; bus.h_wen = 1'b1; bus.h_addr = 8'h00; bus.h_wdata = 8'h50;
        bus.d_req = 1'b1; bus.d_wen = 1'b0; bus.d_addr = 8'h20;
        for (int c = 0; c < 40 && (n < 8 || bus.d_req); c++) begin
            cyc_pre();
            gs.push_back(seen_src);
            if (bus.d_rvalid) begin
                got_d_rv = 1'b1;
                chk("burst_d_rdata", 32'(bus.rdata), 32'(m_mem[8'h20]));
            end
            cyc_post();
            if (seen_src == 1) begin
                n++;
                if (n < 8) begin
                    bus.h_addr = 8'(n); bus.h_wdata = 8'(8'h50 + n);
                end else begin
                    bus.h_req = 1'b0;
                end
            end
            if (seen_src == 2) bus.d_req = 1'b0;
        end
        chk("burst_done", 32'(n), 32'd8);
        for (int k = 0; k < 9; k++) begin
            chk("burst_seq", (k < gs.size()) ? 32'(gs[k]) : 32'hFFFF, 32'(burst_exp[k]));
        end
        idle();
        cyc_pre();
        if (bus.d_rvalid) got_d_rv = 1'b1;
        cyc_post();
        chk("burst_d_rvalid_seen", 32'(got_d_rv), 32'h1);
        for (int k = 0; k < 8; k++) chk("burst_ram", 32'(ram[k]), 32'(8'h50 + k));

        // Data write followed immediately by a read of the same word.
        bus.d_req = 1'b1; bus.d_wen = 1'b1; bus.d_addr = 8'h30; bus.d_wdata = 8'hA5;
        cyc_pre();
        chk("wr_gnt", 32'(bus.d_gnt), 32'h1);
        cyc_post();
        bus.d_wen = 1'b0;
        cyc_pre();
        chk("rd_gnt", 32'(bus.d_gnt), 32'h1);
        chk("wr_no_rvalid", 32'(bus.d_rvalid), 32'h0);
        cyc_post();
        idle();
        cyc_pre();
        chk("rd_rvalid", 32'(bus.d_rvalid), 32'h1);
        chk("rd_rdata", 32'(bus.rdata), 32'hA5);
        cyc_post();

        // Uncontended host read stream.
        bus.h_req = 1'b1; bus.h_wen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            bus.h_addr = 8'(k);
            cyc_pre();
            chk("stream_gnt", 32'(bus.h_gnt), 32'h1);
            chk("stream_burst", 32'(dut.burst_q), 32'h0);
            cyc_post();
        end
        idle();
        cycle();

        // Reset lands while an ifetch read is in flight.
        bus.i_req = 1'b1; bus.i_addr = 8'h07;
        cyc_pre();
        chk("mid_i_gnt", 32'(bus.i_gnt), 32'h1);
        check_now();
        reset = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'({bus.h_gnt, bus.d_gnt, bus.i_gnt}), 32'h0);
        chk("mid_rst_en", 32'(bus.mem_en), 32'h0);
        @(posedge clk);
        model_step();
        #1;
        for (int k = 0; k < 2; k++) begin
            cyc_pre();
            chk("rst_i_rvalid", 32'(bus.i_rvalid), 32'h0);
            chk("rst_gnt", 32'({bus.h_gnt, bus.d_gnt, bus.i_gnt}), 32'h0);
            chk("rst_en_we", 32'({bus.mem_en, bus.mem_we}), 32'h0);
            chk("rst_rdata", 32'(bus.rdata), 32'h0);
            cyc_post();
        end
        bus.d_req = 1'b1; bus.d_wen = 1'b0; bus.d_addr = 8'h40;
        reset = 1'b1;
        cyc_pre();
        chk("post_rst_d_first", 32'(seen_src), 32'd2);
        chk("post_rst_i_rvalid", 32'(bus.i_rvalid), 32'h0);
        cyc_post();
        idle();
        cycle();

        // Randomized traffic; requesters hold until granted.
        for (int c = 0; c < 400; c++) begin
            cycle();
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 149) == 0) reset = 1'b0;
            if (!bus.h_req || seen_src == 1) begin
                bus.h_req = ($urandom_range(0, 1) == 1);
                bus.h_wen = $urandom_range(0, 1) == 1;
                bus.h_addr = 8'($urandom_range(0, 15));
                bus.h_wdata = 8'($urandom);
            end
            if (!bus.d_req || seen_src == 2) begin
                bus.d_req = ($urandom_range(0, 4) < 3);
                bus.d_wen = $urandom_range(0, 1) == 1;
                bus.d_addr = 8'($urandom_range(0, 15));
                bus.d_wdata = 8'($urandom);
            end
            if (!bus.i_req || seen_src == 3) begin
                bus.i_req = ($urandom_range(0, 4) < 3);
                bus.i_addr = 8'($urandom_range(0, 15));
            end
        end
        reset = 1'b1;
        idle();
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
